led_pattern_ctrl: RTL and testbench

- Sequencer for the 8-bit LED bank.
- Selects one of four display patterns and advances it at a programmable step rate derived from the system clock.
- Mode is chosen either by a one-cycle "next mode" pulse (e.g. a debounced button) or by a direct select with valid.
- Sits between board-level user inputs and the LED pins. It replaces a free-running LED counter as the single driver of `led[7:0]`.

---
 rtl/led_pkg.sv | 73 +++++++
 rtl/led_step_timer.sv | 38 +++
 rtl/led_pattern_ctrl.sv | 88 ++++++++
 tb/tb_led_pattern_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and pattern arithmetic for the LED sequencer.
// Holds the mode/direction enums, the per-mode seeds and the single-step rule.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } bounce_dir_e;

    localparam logic [7:0] SEED_COUNT  = 8'h00;
    localparam logic [7:0] SEED_SHIFT  = 8'h01;
    localparam logic [7:0] SEED_BOUNCE = 8'h01;
    localparam logic [7:0] SEED_BLINK  = 8'h00;

    typedef struct packed {
        logic [7:0]  led;
        bounce_dir_e dir;
    } pattern_t;

    function automatic logic [7:0] mode_seed(input led_mode_e m);
        logic [7:0] seed;
        seed = SEED_COUNT;
        case (m)
            MODE_COUNT:  seed = SEED_COUNT;
            MODE_SHIFT:  seed = SEED_SHIFT;
            MODE_BOUNCE: seed = SEED_BOUNCE;
            MODE_BLINK:  seed = SEED_BLINK;
            default:     seed = SEED_COUNT;
        endcase
        return seed;
    endfunction

    // Bounce turns around on the end LED itself so neither end is shown twice in a row.
    function automatic pattern_t pattern_step(input led_mode_e m,
                                              input logic [7:0] cur,
                                              input bounce_dir_e dir);
        pattern_t nxt;
        nxt.led = cur;
        nxt.dir = dir;
        case (m)
            MODE_COUNT:  nxt.led = cur + 8'd1;
            MODE_SHIFT:  nxt.led = {cur[6:0], cur[7]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (cur == 8'h80) begin
                        nxt.led = 8'h40;
                        nxt.dir = DIR_RIGHT;
                    end else begin
                        nxt.led = cur << 1;
                    end
                end else begin
                    if (cur == 8'h01) begin
                        nxt.led = 8'h02;
                        nxt.dir = DIR_LEFT;
                    end else begin
                        nxt.led = cur >> 1;
                    end
                end
            end
            MODE_BLINK:  nxt.led = ~cur;
            default:     nxt.led = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-rate prescaler: counts 0..PERIOD-1 while enabled and flags the last count.
// clr restarts the count so a freshly seeded pattern gets a full step period.
module led_step_timer #(
    parameter int unsigned PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: mode register, pattern register and bounce direction,
// stepped by led_step_timer and reseeded whenever a mode request arrives.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned STEP_FREQ = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_next,
    input  logic       mode_sel_valid,
    input  logic [1:0] mode_sel,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int unsigned STEP_PERIOD = CLK_FREQ / STEP_FREQ;

    generate
        if (STEP_PERIOD < 2) begin : g_bad_period
            $error("led_pattern_ctrl: CLK_FREQ/STEP_FREQ must be at least 2");
        end
    endgenerate

    led_mode_e   mode_q, mode_d;
    logic [7:0]  led_q, led_d;
    bounce_dir_e dir_q, dir_d;
    logic        tick_q, tick_d;

    logic        mode_req;
    led_mode_e   req_mode;
    logic        step_pulse;
    pattern_t    stepped;

    assign mode_req = mode_sel_valid || mode_next;
    assign req_mode = mode_sel_valid ? led_mode_e'(mode_sel)
                                     : led_mode_e'(mode_q + 2'd1);

    led_step_timer #(
        .PERIOD(STEP_PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (mode_req),
        .tick (step_pulse)
    );

    // A mode request wins over a coincident step, which is simply dropped.
    always_comb begin
        mode_d  = mode_q;
        led_d   = led_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        stepped = pattern_step(mode_q, led_q, dir_q);
        if (mode_req) begin
            mode_d = req_mode;
            led_d  = mode_seed(req_mode);
            dir_d  = DIR_LEFT;
        end else if (step_pulse) begin
            led_d  = stepped.led;
            dir_d  = stepped.dir;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_COUNT;
            led_q  <= SEED_COUNT;
            dir_q  <= DIR_LEFT;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with a 4-cycle step period.
// A cycle model pushes expected outputs into a scoreboard queue; scenarios add fixed-value checks.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode_next = 1'b0;
    logic       mode_sel_valid = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic [7:0] led;
    logic [1:0] mode;
    logic       step_tick;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] led;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   checkCount = 0;
    int   failCount = 0;

    logic [1:0] mMode;
    logic [7:0] mLed;
    logic       mDir;
    int         mCnt;
    logic       mTick;

    led_pattern_ctrl #(
        .CLK_FREQ  (8),
        .STEP_FREQ (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .mode_next      (mode_next),
        .mode_sel_valid (mode_sel_valid),
        .mode_sel       (mode_sel),
        .led            (led),
        .mode           (mode),
        .step_tick      (step_tick)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, advances the model, queues the expected outputs, then waits past the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic nx,
                                 input logic v, input logic [1:0] s);
        rst = r; en = e; mode_next = nx; mode_sel_valid = v; mode_sel = s;
        if (r) begin
            mMode = 2'd0; mLed = 8'h00; mDir = 1'b0; mCnt = 0; mTick = 1'b0;
        end else if (v || nx) begin
            mMode = v ? s : mMode + 2'd1;
            mLed  = (mMode == 2'd1 || mMode == 2'd2) ? 8'h01 : 8'h00;
            mDir  = 1'b0; mCnt = 0; mTick = 1'b0;
        end else begin
            mTick = e && (mCnt == 3);
            if (e) mCnt = (mCnt == 3) ? 0 : mCnt + 1;
            if (mTick) begin
                case (mMode)
                    2'd0: mLed = mLed + 8'd1;
                    2'd1: mLed = {mLed[6:0], mLed[7]};
                    2'd2: begin
                        if (!mDir && mLed == 8'h80)      begin mLed = 8'h40; mDir = 1'b1; end
                        else if (mDir && mLed == 8'h01)  begin mLed = 8'h02; mDir = 1'b0; end
                        else if (!mDir)                  mLed = {mLed[6:0], 1'b0};
                        else                             mLed = {1'b0, mLed[7:1]};
                    end
                    default: mLed = ~mLed;
                endcase
            end
        end
        sb.push_back('{mode: mMode, led: mLed, tick: mTick});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
            e = sb.pop_front(); checkCount++;
            if ({mode, led, step_tick} !== e) begin
                failCount++;
                $display("[TB] FAIL reset_sb got mode=%0d led=%h tick=%b exp mode=%0d led=%h tick=%b",
                         mode, led, step_tick, e.mode, e.led, e.tick);
            end
        end
        checkCount++;
        if ({mode, led, step_tick} !== 11'd0) begin
            failCount++;
            $display("[TB] FAIL reset_state got mode=%0d led=%h tick=%b exp 0/00/0", mode, led, step_tick);
        end
    endtask

    task automatic test_count();
        exp_t e;
        int   steps = 0;
        int   sinceTick = 0;
        for (int i = 0; i < 1028; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            sinceTick++;
            e = sb.pop_front(); checkCount++;
            if ({mode, led, step_tick} !== e) begin
                failCount++;
                $display("[TB] FAIL count_sb cyc=%0d got mode=%0d led=%h tick=%b exp mode=%0d led=%h tick=%b",
                         i, mode, led, step_tick, e.mode, e.led, e.tick);
            end
            if (step_tick) begin
                steps++;
                checkCount++;
                if (led !== 8'(steps) || sinceTick != 4) begin
                    failCount++;
                    $display("[TB] FAIL count_step got led=%h gap=%0d exp led=%h gap=4",
                             led, sinceTick, 8'(steps));
                end
                sinceTick = 0;
            end
        end
        checkCount++;
        if (steps != 257 || led !== 8'h01) begin
            failCount++;
            $display("[TB] FAIL count_wrap got steps=%0d led=%h exp steps=257 led=01", steps, led);
        end
    endtask

    task automatic test_bounce();
        exp_t       e;
        logic [7:0] seq [16];
        int         n = 0;
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        e = sb.pop_front(); checkCount++;
        if ({mode, led, step_tick} !== e || led !== 8'h01 || mode !== 2'd2) begin
            failCount++;
            $display("[TB] FAIL bounce_seed got mode=%0d led=%h tick=%b exp mode=2 led=01 tick=0",
                     mode, led, step_tick);
        end
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            e = sb.pop_front(); checkCount++;
            if ({mode, led, step_tick} !== e) begin
                failCount++;
                $display("[TB] FAIL bounce_sb cyc=%0d got mode=%0d led=%h tick=%b exp mode=%0d led=%h tick=%b",
                         i, mode, led, step_tick, e.mode, e.led, e.tick);
            end
            if (step_tick && n < 16) begin
                checkCount++;
                if (led !== seq[n]) begin
                    failCount++;
                    $display("[TB] FAIL bounce_seq step=%0d got led=%h exp led=%h", n, led, seq[n]);
                end
                n++;
            end
        end
        checkCount++;
        if (n != 16) begin
            failCount++;
            $display("[TB] FAIL bounce_steps got %0d exp 16", n);
        end
    endtask

    task automatic test_next_wrap();
        exp_t e;
        int   wait4 = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) void'(sb.pop_front());
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        e = sb.pop_front(); checkCount++;
        if ({mode, led, step_tick} !== e || {mode, led, step_tick} !== 11'd0) begin
            failCount++;
            $display("[TB] FAIL next_wrap got mode=%0d led=%h tick=%b exp mode=0 led=00 tick=0",
                     mode, led, step_tick);
        end
        for (int i = 1; i <= 8 && wait4 == 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            void'(sb.pop_front());
            if (step_tick) wait4 = i;
        end
        checkCount++;
        if (wait4 != 4 || led !== 8'h01) begin
            failCount++;
            $display("[TB] FAIL next_first_step got cycles=%0d led=%h exp cycles=4 led=01", wait4, led);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        for (int i = 0; i < 4 && mCnt != 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            void'(sb.pop_front());
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        e = sb.pop_front(); checkCount++;
        if ({mode, led, step_tick} !== e || mode !== 2'd1 || led !== 8'h01 || step_tick !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL priority got mode=%0d led=%h tick=%b exp mode=1 led=01 tick=0",
                     mode, led, step_tick);
        end
    endtask

    task automatic test_enable_hold();
        exp_t e;
        int   found = 0;
        int   rest = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            e = sb.pop_front(); checkCount++;
            if ({mode, led, step_tick} !== e) begin
                failCount++;
                $display("[TB] FAIL hold_sb got mode=%0d led=%h tick=%b exp mode=%0d led=%h tick=%b",
                         mode, led, step_tick, e.mode, e.led, e.tick);
            end
            if (mTick && mLed == 8'h04) found = 1;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            e = sb.pop_front(); checkCount++;
            if ({mode, led, step_tick} !== e || led !== 8'h04 || step_tick !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL hold_idle cyc=%0d got led=%h tick=%b exp led=04 tick=0",
                         i, led, step_tick);
            end
        end
        for (int i = 1; i <= 8 && rest == 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            void'(sb.pop_front());
            if (step_tick) rest = i;
        end
        checkCount++;
        if (rest != 3 || led !== 8'h08) begin
            failCount++;
            $display("[TB] FAIL hold_resume got cycles=%0d led=%h exp cycles=3 led=08", rest, led);
        end
    endtask

    task automatic test_reset_mid_bounce();
        exp_t e;
        int   gap = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        void'(sb.pop_front());
        for (int i = 0; i < 80 && mDir == 1'b0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            void'(sb.pop_front());
        end
        checkCount++;
        if (mDir !== 1'b1 || led !== mLed) begin
            failCount++;
            $display("[TB] FAIL bounce_right_reached got led=%h dir=%b exp led=%h dir=1", led, mDir, mLed);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        e = sb.pop_front(); checkCount++;
        if ({mode, led, step_tick} !== e || {mode, led, step_tick} !== 11'd0) begin
            failCount++;
            $display("[TB] FAIL mid_reset got mode=%0d led=%h tick=%b exp mode=0 led=00 tick=0",
                     mode, led, step_tick);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        void'(sb.pop_front());
        for (int i = 1; i <= 8 && gap == 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            void'(sb.pop_front());
            if (step_tick) gap = i;
        end
        checkCount++;
        if (gap != 4 || led !== 8'h02 || mode !== 2'd2) begin
            failCount++;
            $display("[TB] FAIL reselect_bounce got cycles=%0d mode=%0d led=%h exp cycles=4 mode=2 led=02",
                     gap, mode, led);
        end
    endtask

    initial begin
        mMode = 2'd0; mLed = 8'h00; mDir = 1'b0; mCnt = 0; mTick = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_count();
        test_bounce();
        test_next_wrap();
        test_priority();
        test_enable_hold();
        test_reset_mid_bounce();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
